my_rr_arbiter: RTL and testbench
================================

Name: my_rr_arbiter

Overview:
- Round-robin arbiter that generates the one-hot lane-select word consumed by the lane mask in the read and write arbiters.
- Takes CTRL_WIDTH requesters, each presenting a packed data lane with valid/last.
- Grants exactly one requester per burst and holds the grant until that burst's last beat.
- Collapses the granted lane (one-hot mask, then OR-reduce) into a single registered output stream with valid/ready.

Parameters:
- DATA_WIDTH, 64, width of one data lane.
- CTRL_WIDTH, 4, number of requesters; also the width of the one-hot grant.
- MAX_BEATS, 16, burst beat cap; used only when MY_ARB_BURST_CAP_EN is defined; legal range ≥1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  CTRL_WIDTH  per-requester beat valid.
- in_last  input  CTRL_WIDTH  per-requester last beat of burst.
- in_data  input  DATA_WIDTH*CTRL_WIDTH  packed lanes; lane i is bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- in_ready  output  CTRL_WIDTH  per-requester beat accept.
- grant  output  CTRL_WIDTH  registered one-hot current owner; all zero when idle.
- out_valid  output  1  output beat valid.
- out_last  output  1  output beat is last of burst.
- out_data  output  DATA_WIDTH  collapsed data of the granted lane.
- out_ready  input  1  downstream accept.
- burst_err  output  1  one-cycle pulse on a forced burst cut; constant 0 when the cap feature is off.

Behaviour:
- Reset (async assert, sync deassert by the upstream reset tree):
  - grant=0, state=IDLE, out_valid=0, out_last=0, out_data=0, burst_err=0.
  - Priority pointer ptr=0, so requester 0 has first priority.
- States:
  - IDLE: no owner.
  - BUSY: grant holds exactly one bit.
- IDLE -> BUSY:
  - Taken when in_valid is nonzero.
  - The winner is the first set in_valid bit scanning upward from ptr, wrapping from CTRL_WIDTH-1 to 0.
  - grant is registered next cycle; no beat is accepted in the arbitration cycle.
  - Arbitration cost is 1 bubble per burst.
- BUSY accept rule:
  - in_ready = grant & {CTRL_WIDTH{~out_valid | out_ready}}.
  - A beat is accepted when in_valid[i] & in_ready[i].
- Output register:
  - Loads on an accepted beat.
  - out_data = OR over i of (lane i & {DATA_WIDTH{grant[i]}}).
  - out_last = in_last of the granted lane.
- Latency: accepted beat appears on out_* the next cycle.
- Output hold: out_valid & ~out_ready holds out_data, out_last and out_valid stable.
- out_valid clears on out_ready when no new beat is accepted in the same cycle.
- Full throughput: with out_ready held at 1 and the owner streaming, 1 beat per cycle.
- BUSY -> IDLE:
  - Taken on an accepted beat with in_last=1.
  - Same cycle: ptr <= index(owner)+1 mod CTRL_WIDTH, grant <= 0.
  - No back-to-back re-grant in the same cycle; re-arbitration happens from IDLE next cycle.
- Boundary conditions:
  - Owner drops in_valid mid-burst: grant held indefinitely; no timeout unless the cap feature is on.
  - Non-owner requests are ignored (in_ready=0) until the owner's burst ends.
  - Single-beat burst (valid & last on the first accepted beat) releases the grant after 1 beat.
  - Only one requester active: it regains the grant every burst; 1 bubble between bursts.
- Invariants:
  - grant is always zero or one-hot.
  - in_ready is never asserted outside grant.

Optional Feature:
- Macro: MY_ARB_BURST_CAP_EN.
- Defined:
  - A beat counter clears on grant and increments per accepted beat.
  - When MAX_BEATS beats are accepted without in_last, the MAX_BEATS-th beat is emitted with out_last forced to 1.
  - The grant is released exactly as for a real last; burst_err pulses 1 cycle, coincident with the grant release.
  - The pointer advances past the owner.
- Undefined:
  - No counter logic; bursts are unbounded.
  - burst_err is tied to 0.

Test Plan:
- Reset, then in_valid=4'b1010: grant=4'b0010 one cycle after the request. A 3-beat burst with data 0x11,0x22,0x33 (last on the 3rd) gives out_data 0x11,0x22,0x33 and out_last on the 3rd only. Then grant=4'b1000.
- All four requesters hold single-beat bursts continuously: grant order 0001,0010,0100,1000,0001. Each out beat carries only its owner's lane; non-owner lanes are set to 0xFFFF_FFFF_FFFF_FFFF and never leak.
- Owner streams 8 beats while out_ready toggles 1,0,0,1,…: no beat is lost or duplicated. out_data stays stable while out_valid & ~out_ready. in_ready is 0 in those cycles.
- Assert rst_n=0 mid-burst at beat 2: grant, out_valid and burst_err go 0 immediately without waiting for clk. After release, requester 0 wins first.
- Only requester 2 active with repeated 1-beat bursts: grant=4'b0100 every other cycle; one idle cycle between bursts.
- With MY_ARB_BURST_CAP_EN and MAX_BEATS=4: a 6-beat burst without last gives beat 4 with out_last=1, burst_err pulsing once, and grant released. Without the macro, all 6 beats pass under one grant and burst_err stays 0.

Source files
------------

// File: rtl/my_rr_arbiter.sv
// Round-robin burst arbiter: grants one requester per burst and collapses the
// granted lane into a single registered valid/ready output stream.
// Optional burst-length cap: define MY_ARB_BURST_CAP_EN to enable MAX_BEATS.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no owner; pick next requester from ptr upward (1 bubble)
//   BUSY  | grant holds one bit; stream owner's beats until its last
module my_rr_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = 4,
   parameter int MAX_BEATS  = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [CTRL_WIDTH-1:0]            in_valid,
   input  logic [CTRL_WIDTH-1:0]            in_last,
   input  logic [DATA_WIDTH*CTRL_WIDTH-1:0] in_data,
   output logic [CTRL_WIDTH-1:0]            in_ready,
   output logic [CTRL_WIDTH-1:0]            grant,
   output logic                             out_valid,
   output logic                             out_last,
   output logic [DATA_WIDTH-1:0]            out_data,
   input  logic                             out_ready,
   output logic                             burst_err
);

   localparam int PTR_W = (CTRL_WIDTH > 1) ? $clog2(CTRL_WIDTH) : 1;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [CTRL_WIDTH-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   logic [CTRL_WIDTH-1:0] win_oh;
   logic [PTR_W-1:0]      owner_idx;
   logic [PTR_W-1:0]      ptr_next;
   logic [DATA_WIDTH-1:0] lane_mux;
   logic                  beat_acc;
   logic                  real_last;
   logic                  beat_last;
   logic                  cap_hit;

   // Accept only on the owner's lane, and only when the output slot is free.
   assign in_ready  = grant_q & {CTRL_WIDTH{~out_valid_q | out_ready}};
   assign beat_acc  = |(in_valid & in_ready);
   assign real_last = |(in_last & grant_q);
   assign beat_last = real_last | cap_hit;

   // Round-robin pick: lowest offset from ptr wins, so scan offsets downward.
   always_comb begin
      logic [PTR_W-1:0] idx;
      win_oh = '0;
      idx    = '0;
      for (int k = CTRL_WIDTH - 1; k >= 0; k--) begin
         idx = PTR_W'((int'(ptr_q) + k) % CTRL_WIDTH);
         if (in_valid[idx]) begin
            win_oh      = '0;
            win_oh[idx] = 1'b1;
         end
      end
   end

   // Encode the owner index and the pointer value just past it.
   always_comb begin
      owner_idx = '0;
      for (int i = 0; i < CTRL_WIDTH; i++) begin
         if (grant_q[i]) owner_idx = PTR_W'(i);
      end
      ptr_next = (int'(owner_idx) == CTRL_WIDTH - 1) ? '0 : owner_idx + 1'b1;
   end

   // Mask every lane by its grant bit and OR-reduce into one word.
   always_comb begin
      lane_mux = '0;
      for (int i = 0; i < CTRL_WIDTH; i++) begin
         lane_mux = lane_mux | (in_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
      end
   end

   // Next-state, grant and pointer; release goes to IDLE so re-arbitration waits a cycle.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (|in_valid) begin
               state_d = BUSY;
               grant_d = win_oh;
            end
         end
         BUSY: begin
            if (beat_acc && beat_last) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = ptr_next;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Output register: load on accept, hold while stalled, drain on ready.
   always_comb begin
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      if (beat_acc) begin
         out_valid_d = 1'b1;
         out_last_d  = beat_last;
         out_data_d  = lane_mux;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Core state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

`ifdef MY_ARB_BURST_CAP_EN
   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             burst_err_q, burst_err_d;

   // The MAX_BEATS-th beat without a real last is cut and marked last.
   assign cap_hit = beat_acc & ~real_last & (cnt_q == CNT_W'(MAX_BEATS - 1));

   // Beat counter is cleared while idle, so every new grant starts from zero.
   always_comb begin
      cnt_d       = cnt_q;
      burst_err_d = cap_hit;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (beat_acc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Cap counter and error pulse; the pulse lines up with the grant release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         burst_err_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         burst_err_q <= burst_err_d;
      end
   end

   assign burst_err = burst_err_q;
`else
   assign cap_hit   = 1'b0;
   // Only an illegal cap setting (below 1) could make this nonzero.
   assign burst_err = (MAX_BEATS < 1);
`endif

   assign grant     = grant_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_my_rr_arbiter.sv
// Scoreboard bench for my_rr_arbiter: lane queues drive requesters, expected
// beats are queued on load and checked by an independent output monitor.
module tb_my_rr_arbiter;
   localparam int DW = 64;
   localparam int CW = 4;
   localparam int MB = 4;
`ifdef MY_ARB_BURST_CAP_EN
   localparam bit CAP_EN = 1'b1;
`else
   localparam bit CAP_EN = 1'b0;
`endif

   typedef logic [DW:0] beat_t;   // {last, data}

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [CW-1:0]    in_valid = '0;
   logic [CW-1:0]    in_last = '0;
   logic [DW*CW-1:0] in_data = '1;
   logic [CW-1:0]    in_ready;
   logic [CW-1:0]    grant;
   logic             out_valid;
   logic             out_last;
   logic [DW-1:0]    out_data;
   logic             out_ready = 1'b1;
   logic             burst_err;

   beat_t         lane_q [CW][$];
   beat_t         exp_q[$];
   logic [CW-1:0] glog[$];
   logic [CW-1:0] hs = '0;
   logic [CW-1:0] prev_g = '0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
   bit            stall_prev = 1'b0;
   bit            rdy_mode = 1'b0;
   int            n_cmp = 0;
   int            n_err = 0;
   int            beats_seen = 0;
   int            berr_cnt = 0;
   int            cyc = 0;

   my_rr_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .MAX_BEATS(MB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .grant     (grant),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_data  (out_data),
      .out_ready (out_ready),
      .burst_err (burst_err)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input beat_t act, input beat_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive_lanes();
      for (int i = 0; i < CW; i++) begin
         if (lane_q[i].size() > 0) begin
            in_valid[i]           = 1'b1;
            in_last[i]            = lane_q[i][0][DW];
            in_data[i*DW +: DW]   = lane_q[i][0][DW-1:0];
         end else begin
            in_valid[i]           = 1'b0;
            in_last[i]            = 1'b0;
            in_data[i*DW +: DW]   = {DW{1'b1}};
         end
      end
      out_ready = rdy_mode ? (cyc % 3 == 0) : 1'b1;
   endtask

   // Handshakes are sampled mid-cycle, applied just after the next edge.
   always @(negedge clk) hs = in_valid & in_ready;

   always @(posedge clk) begin
      #1;
      cyc++;
      for (int i = 0; i < CW; i++) begin
         if (hs[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
      end
      hs = '0;
      drive_lanes();
   end

   // Output monitor: scoreboard pop, stall stability, grant/ready invariants.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("grant_onehot0", beat_t'(grant & (grant - 1'b1)), beat_t'(0));
         chk("ready_in_grant", beat_t'(in_ready & ~grant), beat_t'(0));
         if (out_valid && !out_ready) chk("ready_in_stall", beat_t'(in_ready), beat_t'(0));
         if (stall_prev) chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
         stall_prev = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", {out_last, out_data}, beat_t'(0) - 1'b1);
            end else begin
               chk("out_beat", {out_last, out_data}, exp_q.pop_front());
            end
            beats_seen++;
         end
         if (burst_err) berr_cnt++;
         if (grant != '0 && grant != prev_g) glog.push_back(grant);
         prev_g = grant;
      end else begin
         stall_prev = 1'b0;
         prev_g     = '0;
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_beats(input int n, input string nm);
      int t = 0;
      while (beats_seen < n && t < 300) begin
         step(1);
         t++;
      end
      chk(nm, beat_t'(beats_seen), beat_t'(n));
   endtask

   task automatic chk_glog(input string nm, input logic [CW-1:0] e[$]);
      chk({nm, "_count"}, beat_t'(glog.size()), beat_t'(e.size()));
      for (int i = 0; i < e.size() && i < glog.size(); i++) chk(nm, beat_t'(glog[i]), beat_t'(e[i]));
   endtask

   task automatic load(input int lane, input logic last, input logic [DW-1:0] d);
      lane_q[lane].push_back({last, d});
   endtask

   initial begin
      logic [CW-1:0] eg[$];
      int base;
      int b0;

      // Reset values
      step(2);
      chk("rst_state", {grant, out_valid, out_last, burst_err}, beat_t'(0));
      chk("rst_data", beat_t'(out_data), beat_t'(0));
      rst_n = 1'b1;
      step(2);

      // 1: requesters 1 and 3; 3-beat burst on lane 1, then lane 3
      glog.delete();
      base = beats_seen;
      load(1, 1'b0, 64'h11); load(1, 1'b0, 64'h22); load(1, 1'b1, 64'h33);
      load(3, 1'b1, 64'hD3);
      exp_q.push_back({1'b0, 64'h11}); exp_q.push_back({1'b0, 64'h22});
      exp_q.push_back({1'b1, 64'h33}); exp_q.push_back({1'b1, 64'hD3});
      step(1);
      chk("arb_cycle_grant", beat_t'(grant), beat_t'(0));
      chk("arb_cycle_ready", beat_t'(in_ready), beat_t'(0));
      step(1);
      chk("first_grant", beat_t'(grant), beat_t'(4'b0010));
      wait_beats(base + 4, "t1_beats");
      step(3);
      eg = '{4'b0010, 4'b1000};
      chk_glog("t1_order", eg);
      chk("t1_idle", beat_t'(grant), beat_t'(0));

      // 2: all four requesters with single-beat bursts, two rounds
      glog.delete();
      base = beats_seen;
      for (int r = 0; r < 2; r++) begin
         for (int l = 0; l < CW; l++) begin
            load(l, 1'b1, 64'h200 + 64'(l * 16 + r));
            exp_q.push_back({1'b1, 64'h200 + 64'(l * 16 + r)});
         end
      end
      wait_beats(base + 8, "t2_beats");
      step(3);
      eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      chk_glog("t2_order", eg);

      // 3: 8-beat burst with downstream stalls
      rdy_mode = 1'b1;
      base = beats_seen;
      for (int k = 1; k <= 8; k++) begin
         load(0, (k == 8), 64'h300 + 64'(k));
         exp_q.push_back({(k == 8), 64'h300 + 64'(k)});
      end
      wait_beats(base + 8, "t3_beats");
      step(3);
      rdy_mode = 1'b0;
      chk("t3_drained", beat_t'(exp_q.size()), beat_t'(0));

      // 4: async reset mid-burst after beat 2, then requester 0 wins first
      base = beats_seen;
      for (int k = 1; k <= 4; k++) load(1, (k == 4), 64'h400 + 64'(k));
      exp_q.push_back({1'b0, 64'h401}); exp_q.push_back({1'b0, 64'h402});
      wait_beats(base + 2, "t4_pre_beats");
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst", {grant, out_valid, burst_err}, beat_t'(0));
      for (int i = 0; i < CW; i++) lane_q[i].delete();
      hs = '0;
      exp_q.delete();
      step(2);
      rst_n = 1'b1;
      step(1);
      glog.delete();
      base = beats_seen;
      load(3, 1'b1, 64'h4D); load(1, 1'b1, 64'h4B); load(0, 1'b1, 64'h4A);
      exp_q.push_back({1'b1, 64'h4A}); exp_q.push_back({1'b1, 64'h4B});
      exp_q.push_back({1'b1, 64'h4D});
      wait_beats(base + 3, "t4_beats");
      step(3);
      eg = '{4'b0001, 4'b0010, 4'b1000};
      chk_glog("t4_order", eg);

      // 5: lone requester 2, single-beat bursts -> grant every other cycle
      base = beats_seen;
      for (int k = 0; k < 3; k++) begin
         load(2, 1'b1, 64'h500 + 64'(k));
         exp_q.push_back({1'b1, 64'h500 + 64'(k)});
      end
      for (int c = 1; c <= 7; c++) begin
         step(1);
         chk("t5_grant_seq", beat_t'(grant), (c % 2 == 0) ? beat_t'(4'b0100) : beat_t'(0));
      end
      wait_beats(base + 3, "t5_beats");

      // 6: 6 beats without last; cap cuts at beat MB only when enabled
      step(2);
      glog.delete();
      base = beats_seen;
      b0 = berr_cnt;
      for (int k = 1; k <= 6; k++) begin
         load(0, 1'b0, 64'h600 + 64'(k));
         exp_q.push_back({CAP_EN && (k == MB), 64'h600 + 64'(k)});
      end
      wait_beats(base + 6, "t6_beats");
      step(2);
      chk("t6_grant_held", beat_t'(grant), beat_t'(4'b0001));
      chk("t6_burst_err", beat_t'(berr_cnt - b0), beat_t'(CAP_EN));
      load(0, 1'b1, 64'h607);
      exp_q.push_back({1'b1, 64'h607});
      wait_beats(base + 7, "t6_last_beat");
      step(3);
      chk("t6_grants", beat_t'(glog.size()), CAP_EN ? beat_t'(2) : beat_t'(1));
      chk("t6_idle", beat_t'(grant), beat_t'(0));
      chk("t6_err_total", beat_t'(berr_cnt - b0), beat_t'(CAP_EN));
      chk("final_drained", beat_t'(exp_q.size()), beat_t'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
